// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the writeback stage: opcode/funct
// constants, the bubble PC marker and the write-back source selector.
package pipeline_pkg;

    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] FUNCT_JALR = 6'h09;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC8 = 2'd2
    } wb_src_e;

    // Map an instruction's opcode/funct to its write-back source.
    function automatic wb_src_e wb_src_decode(input logic [5:0] opcode,
                                              input logic [5:0] funct);
        wb_src_e src;
        case (opcode)
            OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: src = WB_MEM;
            OP_JAL:                              src = WB_PC8;
            OP_SPECIAL: begin
                if (funct == FUNCT_JALR) begin
                    src = WB_PC8;
                end else begin
                    src = WB_ALU;
                end
            end
            default:                             src = WB_ALU;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/w_stage_grf_load_ext.sv
// Sub-word load extractor: picks the byte/half selected by the address
// offset out of the aligned memory word and sign- or zero-extends it.
module w_load_ext
    import pipeline_pkg::*;
(
    input  logic [31:0] W_RD,
    input  logic [1:0]  off,
    input  logic [5:0]  opcode,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte; halves use only off[1] (alignment checked upstream).
    always_comb begin
        byte_s = 8'h00;
        case (off)
            2'd0:    byte_s = W_RD[7:0];
            2'd1:    byte_s = W_RD[15:8];
            2'd2:    byte_s = W_RD[23:16];
            2'd3:    byte_s = W_RD[31:24];
            default: byte_s = 8'h00;
        endcase
        if (off[1]) begin
            half_s = W_RD[31:16];
        end else begin
            half_s = W_RD[15:0];
        end
    end

    // Extend according to the load flavour; lw passes the word through.
    always_comb begin
        data = W_RD;
        case (opcode)
            OP_LB:   data = {{24{byte_s[7]}}, byte_s};
            OP_LBU:  data = {24'h00_0000, byte_s};
            OP_LH:   data = {{16{half_s[15]}}, half_s};
            OP_LHU:  data = {16'h0000, half_s};
            OP_LW:   data = W_RD;
            default: data = W_RD;
        endcase
    end

endmodule

// File: rtl/w_stage_grf.sv
// Writeback stage plus 32x32 general register file with W->D bypass and a
// retired-instruction counter.
// Optional macro GRF_DISPLAY_EN: when defined, each register write is
// printed as "@pc: $reg <= data" in simulation; logic is unchanged.
module w_stage_grf #(
    parameter int          DATA_W = 32,
    parameter logic [31:0] RST_PC = pipeline_pkg::RST_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       W_instr,
    input  logic [4:0]        W_A3,
    input  logic [DATA_W-1:0] W_AR,
    input  logic [DATA_W-1:0] W_RD,
    input  logic [DATA_W-1:0] W_pc8,
    input  logic [31:0]       W_pc,
    input  logic [4:0]        D_rs_addr,
    input  logic [4:0]        D_rt_addr,
    output logic [DATA_W-1:0] D_rs_data,
    output logic [DATA_W-1:0] D_rt_data,
    output logic [DATA_W-1:0] W_wd,
    output logic              W_we,
    output logic [31:0]       W_retired_cnt
);
    import pipeline_pkg::*;

    logic [DATA_W-1:0] grf_r [0:31];
    logic [31:0]       retired_cnt_r;
    logic [DATA_W-1:0] load_data_s;
    wb_src_e           wb_src_s;
    logic              unused_instr_s;

    assign unused_instr_s = ^W_instr[25:6];

    w_load_ext u_load_ext (
        .W_RD   (W_RD),
        .off    (W_AR[1:0]),
        .opcode (W_instr[31:26]),
        .data   (load_data_s)
    );

    // Choose the write-back value from ALU, memory or link path.
    always_comb begin
        wb_src_s = wb_src_decode(W_instr[31:26], W_instr[5:0]);
        W_wd     = W_AR;
        case (wb_src_s)
            WB_ALU:  W_wd = W_AR;
            WB_MEM:  W_wd = load_data_s;
            WB_PC8:  W_wd = W_pc8;
            default: W_wd = W_AR;
        endcase
    end

    assign W_we = (W_A3 != 5'd0) && reset;

    // Register array: cleared on reset, written on each enabled edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                grf_r[i] <= '0;
            end
        end else if (W_we) begin
            grf_r[W_A3] <= W_wd;
        end else begin
            grf_r[W_A3] <= grf_r[W_A3];
        end
    end

    // Read ports: $zero and reset read 0, same-cycle write is bypassed.
    always_comb begin
        D_rs_data = '0;
        D_rt_data = '0;
        if (!reset || D_rs_addr == 5'd0) begin
            D_rs_data = '0;
        end else if (W_we && W_A3 == D_rs_addr) begin
            D_rs_data = W_wd;
        end else begin
            D_rs_data = grf_r[D_rs_addr];
        end
        if (!reset || D_rt_addr == 5'd0) begin
            D_rt_data = '0;
        end else if (W_we && W_A3 == D_rt_addr) begin
            D_rt_data = W_wd;
        end else begin
            D_rt_data = grf_r[D_rt_addr];
        end
    end

    // Count every non-bubble instruction that reaches writeback.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_cnt_r <= 32'd0;
        end else if (W_instr != 32'd0 || W_pc != RST_PC) begin
            retired_cnt_r <= retired_cnt_r + 32'd1;
        end else begin
            retired_cnt_r <= retired_cnt_r;
        end
    end

    assign W_retired_cnt = retired_cnt_r;

`ifdef GRF_DISPLAY_EN
    // Trace each register write for simulation logs.
    always @(posedge clk) begin
        if (W_we) begin
            $display("@%h: $%d <= %h", W_pc, W_A3, W_wd);
        end
    end
`else
    // Tracing disabled: no simulation output.
`endif

endmodule

// File: tb/tb_w_stage_grf.sv
// Self-checking bench for w_stage_grf: directed table, reset/counter
// sequences and random stimulus against a behavioural model.
module tb_w_stage_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] W_instr, W_AR, W_RD, W_pc8, W_pc;
    logic [4:0]  W_A3, D_rs_addr, D_rt_addr;
    logic [31:0] D_rs_data, D_rt_data, W_wd, W_retired_cnt;
    logic        W_we;

    int checks = 0;
    int passes = 0;

    logic [31:0] ref_grf [0:31];
    logic [31:0] ref_cnt;

    w_stage_grf dut (
        .clk(clk), .reset(reset), .W_instr(W_instr), .W_A3(W_A3),
        .W_AR(W_AR), .W_RD(W_RD), .W_pc8(W_pc8), .W_pc(W_pc),
        .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
        .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
        .W_wd(W_wd), .W_we(W_we), .W_retired_cnt(W_retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected write-back value from the instruction-set rules.
    function automatic logic [31:0] model_wd(input logic [31:0] instr, input logic [31:0] ar,
                                             input logic [31:0] rd, input logic [31:0] pc8);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] b;
        logic [31:0] h;
        op = instr[31:26];
        fn = instr[5:0];
        b  = (rd >> (8 * ar[1:0])) & 32'h0000_00FF;
        h  = (rd >> (16 * ar[1])) & 32'h0000_FFFF;
        if (op == 6'h23) return rd;
        if (op == 6'h20) return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
        if (op == 6'h24) return b;
        if (op == 6'h21) return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
        if (op == 6'h25) return h;
        if (op == 6'h03 || (op == 6'h00 && fn == 6'h09)) return pc8;
        return ar;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic [4:0] a3,
                                               input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (a3 == a) return wd;
        return ref_grf[a];
    endfunction

    // Drive one W-stage transaction and compare all combinational outputs.
    task automatic drive_check(input logic [31:0] instr, input logic [4:0] a3,
                               input logic [31:0] ar, input logic [31:0] rd,
                               input logic [31:0] pc8, input logic [31:0] pc,
                               input logic [4:0] rs, input logic [4:0] rt);
        logic [31:0] wd;
        W_instr = instr; W_A3 = a3; W_AR = ar; W_RD = rd; W_pc8 = pc8; W_pc = pc;
        D_rs_addr = rs; D_rt_addr = rt;
        #1;
        wd = model_wd(instr, ar, rd, pc8);
        chk("wd", W_wd, wd);
        chk("we", {31'd0, W_we}, {31'd0, a3 != 5'd0});
        chk("rs", D_rs_data, model_read(rs, a3, wd));
        chk("rt", D_rt_data, model_read(rt, a3, wd));
        chk("cnt", W_retired_cnt, ref_cnt);
    endtask

    // Advance one clock edge and update the model for the current inputs.
    task automatic commit();
        logic [31:0] wd;
        wd = model_wd(W_instr, W_AR, W_RD, W_pc8);
        @(posedge clk);
        if (W_A3 != 5'd0) ref_grf[W_A3] = wd;
        if (W_instr != 32'd0 || W_pc != 32'h0000_3000) ref_cnt = ref_cnt + 32'd1;
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  a3;
        logic [31:0] ar;
        logic [31:0] pc8;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t tbl [9];

    logic [5:0] ops [10];
    logic [31:0] rnd_instr;
    logic [4:0]  rnd_a3;

    initial begin
        for (int i = 0; i < 32; i++) ref_grf[i] = 32'd0;
        ref_cnt = 32'd0;
        reset = 1'b0;
        W_instr = 32'd0; W_A3 = 5'd0; W_AR = 32'd0; W_RD = 32'd0;
        W_pc8 = 32'd0; W_pc = 32'h0000_3000; D_rs_addr = 5'd1; D_rt_addr = 5'd2;

        tbl[0] = '{32'h3400_0000, 5'd8,  32'h0000_00FF, 32'd0,         32'h0000_00FF};
        tbl[1] = '{32'h8000_0000, 5'd9,  32'h0000_1003, 32'd0,         32'hFFFF_FF80};
        tbl[2] = '{32'h9000_0000, 5'd10, 32'h0000_1003, 32'd0,         32'h0000_0080};
        tbl[3] = '{32'h8400_0000, 5'd11, 32'h0000_1002, 32'd0,         32'hFFFF_8081};
        tbl[4] = '{32'h9400_0000, 5'd12, 32'h0000_1000, 32'd0,         32'h0000_7F02};
        tbl[5] = '{32'h8C00_0000, 5'd13, 32'h0000_1000, 32'd0,         32'h8081_7F02};
        tbl[6] = '{32'h0C00_0000, 5'd31, 32'h0000_0000, 32'h0000_3010, 32'h0000_3010};
        tbl[7] = '{32'h0000_0009, 5'd4,  32'h0000_0000, 32'h0000_3020, 32'h0000_3020};
        tbl[8] = '{32'h3400_0000, 5'd0,  32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF};

        // Reset state.
        @(posedge clk); #1;
        chk("rst_we", {31'd0, W_we}, 32'd0);
        chk("rst_cnt", W_retired_cnt, 32'd0);
        chk("rst_rs", D_rs_data, 32'd0);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // Directed table: same-cycle bypass, then read back from the array.
        for (int i = 0; i < 9; i++) begin
            drive_check(tbl[i].instr, tbl[i].a3, tbl[i].ar, 32'h8081_7F02, tbl[i].pc8,
                        32'h0000_3004 + 32'(4 * i), tbl[i].a3, 5'd0);
            chk("tbl_wd", W_wd, tbl[i].exp_wd);
            chk("tbl_byp", D_rs_data, (tbl[i].a3 == 5'd0) ? 32'd0 : tbl[i].exp_wd);
            commit();
            drive_check(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h0000_3000, tbl[i].a3, tbl[i].a3);
            chk("tbl_rb", D_rt_data, (tbl[i].a3 == 5'd0) ? 32'd0 : tbl[i].exp_wd);
            commit();
        end

        // Mid-run reset after writing grf[5].
        drive_check(32'h3400_0000, 5'd5, 32'h1234_5678, 32'd0, 32'd0, 32'h0000_3100, 5'd5, 5'd0);
        commit();
        drive_check(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h0000_3000, 5'd5, 5'd5);
        chk("pre_rst_r5", D_rs_data, 32'h1234_5678);
        W_instr = 32'h3400_0000; W_A3 = 5'd5; W_AR = 32'h0000_0777;
        reset = 1'b0;
        #1;
        chk("mrst_rs", D_rs_data, 32'd0);
        chk("mrst_cnt", W_retired_cnt, 32'd0);
        chk("mrst_we", {31'd0, W_we}, 32'd0);
        chk("mrst_wd", W_wd, 32'h0000_0777);
        for (int i = 0; i < 32; i++) ref_grf[i] = 32'd0;
        ref_cnt = 32'd0;
        @(posedge clk); #1;
        chk("mrst_hold", W_retired_cnt, 32'd0);
        reset = 1'b1;
        drive_check(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h0000_3000, 5'd5, 5'd8);
        chk("post_rst_r5", D_rs_data, 32'd0);
        commit();

        // Counter wrap and bubble hold.
        force dut.retired_cnt_r = 32'hFFFF_FFFF;
        #1 release dut.retired_cnt_r;
        ref_cnt = 32'hFFFF_FFFF;
        drive_check(32'h3400_0000, 5'd7, 32'h0000_0011, 32'd0, 32'd0, 32'h0000_3200, 5'd7, 5'd0);
        commit();
        chk("wrap", W_retired_cnt, 32'd0);
        drive_check(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h0000_3000, 5'd0, 5'd7);
        commit();
        chk("bubble", W_retired_cnt, 32'd0);

        // Random traffic against the model.
        ops = '{6'h23, 6'h20, 6'h24, 6'h21, 6'h25, 6'h03, 6'h00, 6'h0D, 6'h0F, 6'h2B};
        for (int n = 0; n < 400; n++) begin
            rnd_instr = $urandom;
            rnd_instr[31:26] = ops[$urandom_range(0, 9)];
            if (rnd_instr[31:26] == 6'h00 && $urandom_range(0, 1) == 0) rnd_instr[5:0] = 6'h09;
            if ($urandom_range(0, 9) == 0) rnd_instr = 32'd0;
            rnd_a3 = 5'($urandom_range(0, 31));
            drive_check(rnd_instr, rnd_a3, $urandom, $urandom, $urandom,
                        ($urandom_range(0, 3) == 0) ? 32'h0000_3000 : $urandom,
                        ($urandom_range(0, 3) == 0) ? rnd_a3 : 5'($urandom_range(0, 31)),
                        ($urandom_range(0, 3) == 0) ? rnd_a3 : 5'($urandom_range(0, 31)));
            commit();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
